// File: rtl/crate_array_packer.sv
// Snapshots a 38x38 hit array plus header on a strobe and streams it out as one framed
// 16-bit valid/ready packet. Optional CRC-16-CCITT trailer word when PACKER_CRC_EN is defined.
module crate_array_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        arr_valid,
    input  logic [15:0] array_header,
    input  logic [37:0] array_in00,
    input  logic [37:0] array_in01,
    input  logic [37:0] array_in02,
    input  logic [37:0] array_in03,
    input  logic [37:0] array_in04,
    input  logic [37:0] array_in05,
    input  logic [37:0] array_in06,
    input  logic [37:0] array_in07,
    input  logic [37:0] array_in08,
    input  logic [37:0] array_in09,
    input  logic [37:0] array_in10,
    input  logic [37:0] array_in11,
    input  logic [37:0] array_in12,
    input  logic [37:0] array_in13,
    input  logic [37:0] array_in14,
    input  logic [37:0] array_in15,
    input  logic [37:0] array_in16,
    input  logic [37:0] array_in17,
    input  logic [37:0] array_in18,
    input  logic [37:0] array_in19,
    input  logic [37:0] array_in20,
    input  logic [37:0] array_in21,
    input  logic [37:0] array_in22,
    input  logic [37:0] array_in23,
    input  logic [37:0] array_in24,
    input  logic [37:0] array_in25,
    input  logic [37:0] array_in26,
    input  logic [37:0] array_in27,
    input  logic [37:0] array_in28,
    input  logic [37:0] array_in29,
    input  logic [37:0] array_in30,
    input  logic [37:0] array_in31,
    input  logic [37:0] array_in32,
    input  logic [37:0] array_in33,
    input  logic [37:0] array_in34,
    input  logic [37:0] array_in35,
    input  logic [37:0] array_in36,
    input  logic [37:0] array_in37,
    output logic [15:0] dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        dout_last,
    output logic        busy,
    output logic [7:0]  drop_cnt
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_HEAD  = 3'd1;
    localparam logic [2:0] ST_ROW   = 3'd2;
    localparam logic [2:0] ST_TRAIL = 3'd3;
`ifdef PACKER_CRC_EN
    localparam logic [2:0] ST_CRC   = 3'd4;
`endif

    // Stream handshake: a word transfers on a rising edge where dout_valid && dout_ready.
    // dout/dout_valid/dout_last are decoded from registered state only, so they hold
    // steady for as long as the consumer stalls.

    logic [37:0] rows_in [38];
    logic [37:0] snap_q  [38];
    logic [37:0] snap_d  [38];
    logic [15:0] hdr_q, hdr_d;
    logic [2:0]  state_q, state_d;
    logic [5:0]  row_q, row_d;
    logic [1:0]  sub_q, sub_d;
    logic [10:0] pop_q, pop_d;
    logic [7:0]  drop_q, drop_d;
    logic [37:0] cur_row;
    logic [5:0]  row_pop;
    logic        hs;

    assign rows_in[0]  = array_in00;
    assign rows_in[1]  = array_in01;
    assign rows_in[2]  = array_in02;
    assign rows_in[3]  = array_in03;
    assign rows_in[4]  = array_in04;
    assign rows_in[5]  = array_in05;
    assign rows_in[6]  = array_in06;
    assign rows_in[7]  = array_in07;
    assign rows_in[8]  = array_in08;
    assign rows_in[9]  = array_in09;
    assign rows_in[10] = array_in10;
    assign rows_in[11] = array_in11;
    assign rows_in[12] = array_in12;
    assign rows_in[13] = array_in13;
    assign rows_in[14] = array_in14;
    assign rows_in[15] = array_in15;
    assign rows_in[16] = array_in16;
    assign rows_in[17] = array_in17;
    assign rows_in[18] = array_in18;
    assign rows_in[19] = array_in19;
    assign rows_in[20] = array_in20;
    assign rows_in[21] = array_in21;
    assign rows_in[22] = array_in22;
    assign rows_in[23] = array_in23;
    assign rows_in[24] = array_in24;
    assign rows_in[25] = array_in25;
    assign rows_in[26] = array_in26;
    assign rows_in[27] = array_in27;
    assign rows_in[28] = array_in28;
    assign rows_in[29] = array_in29;
    assign rows_in[30] = array_in30;
    assign rows_in[31] = array_in31;
    assign rows_in[32] = array_in32;
    assign rows_in[33] = array_in33;
    assign rows_in[34] = array_in34;
    assign rows_in[35] = array_in35;
    assign rows_in[36] = array_in36;
    assign rows_in[37] = array_in37;

    function automatic logic [5:0] popcount38(input logic [37:0] v);
        logic [5:0] c;
        c = 6'd0;
        for (int i = 0; i < 38; i++) begin
            c = c + {5'd0, v[i]};
        end
        return c;
    endfunction

`ifdef PACKER_CRC_EN
    logic [15:0] crc_q, crc_d;

    // CRC-16-CCITT, polynomial 0x1021, data consumed MSB first.
    function automatic logic [15:0] crc16_word(input logic [15:0] c_in, input logic [15:0] d);
        logic [15:0] c;
        logic        fb;
        c = c_in;
        for (int i = 15; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0};
            if (fb) begin
                c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction
`endif

    assign cur_row    = snap_q[row_q];
    assign row_pop    = popcount38(cur_row);
    assign busy       = (state_q != ST_IDLE);
    assign dout_valid = busy;
    assign drop_cnt   = drop_q;
    assign hs         = dout_valid && dout_ready;

    always_comb begin
        dout      = 16'h0000;
        dout_last = 1'b0;
        case (state_q)
            ST_HEAD: dout = hdr_q;
            ST_ROW: begin
                case (sub_q)
                    2'd0:    dout = {row_q, 4'b0000, cur_row[37:32]};
                    2'd1:    dout = cur_row[31:16];
                    default: dout = cur_row[15:0];
                endcase
            end
            ST_TRAIL: begin
                dout = {5'b11110, pop_q};
`ifndef PACKER_CRC_EN
                dout_last = 1'b1;
`endif
            end
`ifdef PACKER_CRC_EN
            ST_CRC: begin
                dout      = crc_q;
                dout_last = 1'b1;
            end
`endif
            default: dout = 16'h0000;
        endcase
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        sub_d   = sub_q;
        pop_d   = pop_q;
        hdr_d   = hdr_q;
        snap_d  = snap_q;
        drop_d  = drop_q;
`ifdef PACKER_CRC_EN
        crc_d   = crc_q;
        if (hs && state_q != ST_CRC) begin
            crc_d = crc16_word(crc_q, dout);
        end
`endif
        // Strobes outside IDLE never touch the snapshot; they are only counted.
        if (arr_valid && state_q != ST_IDLE && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end
        case (state_q)
            ST_IDLE: begin
                if (arr_valid) begin
                    hdr_d   = array_header;
                    snap_d  = rows_in;
                    pop_d   = 11'd0;
                    row_d   = 6'd0;
                    sub_d   = 2'd0;
`ifdef PACKER_CRC_EN
                    crc_d   = 16'hFFFF;
`endif
                    state_d = ST_HEAD;
                end
            end
            ST_HEAD: begin
                if (hs) begin
                    state_d = ST_ROW;
                end
            end
            ST_ROW: begin
                if (hs) begin
                    if (sub_q == 2'd2) begin
                        sub_d = 2'd0;
                        pop_d = pop_q + {5'd0, row_pop};
                        if (row_q == 6'd37) begin
                            state_d = ST_TRAIL;
                        end else begin
                            row_d = row_q + 6'd1;
                        end
                    end else begin
                        sub_d = sub_q + 2'd1;
                    end
                end
            end
            ST_TRAIL: begin
                if (hs) begin
`ifdef PACKER_CRC_EN
                    state_d = ST_CRC;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef PACKER_CRC_EN
            ST_CRC: begin
                if (hs) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            row_q   <= 6'd0;
            sub_q   <= 2'd0;
            pop_q   <= 11'd0;
            drop_q  <= 8'd0;
`ifdef PACKER_CRC_EN
            crc_q   <= 16'hFFFF;
`endif
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            sub_q   <= sub_d;
            pop_q   <= pop_d;
            drop_q  <= drop_d;
`ifdef PACKER_CRC_EN
            crc_q   <= crc_d;
`endif
        end
    end

    // Snapshot storage has no reset; its contents only matter after a capture.
    always_ff @(posedge clk) begin
        hdr_q  <= hdr_d;
        snap_q <= snap_d;
    end

endmodule

// File: tb/tb_crate_array_packer.sv
// Directed bench for crate_array_packer; follows PACKER_CRC_EN when it is defined.
module tb_crate_array_packer;

`ifdef PACKER_CRC_EN
    localparam int PKT_LEN = 117;
`else
    localparam int PKT_LEN = 116;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arr_valid = 1'b0;
    logic [15:0] array_header = 16'h0000;
    logic [37:0] rows [38];
    logic [15:0] dout;
    logic        dout_valid;
    logic        dout_ready = 1'b0;
    logic        dout_last;
    logic        busy;
    logic [7:0]  drop_cnt;

    int          tests = 0;
    int          failed = 0;
    logic [15:0] exp_q [$];
    logic [15:0] got_q [$];
    logic        last_q [$];
    logic [15:0] ref_q [$];
    bit          rst_hit;

    always #5 clk = ~clk;

    crate_array_packer dut (
        .clk(clk), .rst(rst), .arr_valid(arr_valid), .array_header(array_header),
        .array_in00(rows[0]),  .array_in01(rows[1]),  .array_in02(rows[2]),  .array_in03(rows[3]),
        .array_in04(rows[4]),  .array_in05(rows[5]),  .array_in06(rows[6]),  .array_in07(rows[7]),
        .array_in08(rows[8]),  .array_in09(rows[9]),  .array_in10(rows[10]), .array_in11(rows[11]),
        .array_in12(rows[12]), .array_in13(rows[13]), .array_in14(rows[14]), .array_in15(rows[15]),
        .array_in16(rows[16]), .array_in17(rows[17]), .array_in18(rows[18]), .array_in19(rows[19]),
        .array_in20(rows[20]), .array_in21(rows[21]), .array_in22(rows[22]), .array_in23(rows[23]),
        .array_in24(rows[24]), .array_in25(rows[25]), .array_in26(rows[26]), .array_in27(rows[27]),
        .array_in28(rows[28]), .array_in29(rows[29]), .array_in30(rows[30]), .array_in31(rows[31]),
        .array_in32(rows[32]), .array_in33(rows[33]), .array_in34(rows[34]), .array_in35(rows[35]),
        .array_in36(rows[36]), .array_in37(rows[37]),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_last(dout_last),
        .busy(busy), .drop_cnt(drop_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] crc_ref(input logic [15:0] c_in, input logic [15:0] d);
        logic [15:0] c;
        c = c_in;
        for (int i = 15; i >= 0; i--) begin
            if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    // Reference packet built from the bench's own copy of the array.
    task automatic build_exp();
        int          pop;
        logic [5:0]  r6;
        logic [15:0] crc;
        exp_q.delete();
        pop = 0;
        exp_q.push_back(array_header);
        for (int r = 0; r < 38; r++) begin
            r6 = 6'(r);
            exp_q.push_back({r6, 4'b0000, rows[r][37:32]});
            exp_q.push_back(rows[r][31:16]);
            exp_q.push_back(rows[r][15:0]);
            pop += $countones(rows[r]);
        end
        exp_q.push_back({5'b11110, 11'(pop)});
`ifdef PACKER_CRC_EN
        crc = 16'hFFFF;
        for (int i = 0; i < 116; i++) crc = crc_ref(crc, exp_q[i]);
        exp_q.push_back(crc);
`else
        crc = 16'h0000;
`endif
    endtask

    task automatic start_packet();
        @(negedge clk);
        arr_valid = 1'b1;
        @(posedge clk);
    endtask

    task automatic run_packet(input bit rand_ready, input int strobe_a, input int strobe_b,
                              input int rst_at);
        int          idx;
        int          cyc;
        bit          stalled;
        bit          done;
        logic [15:0] prev;
        logic        prev_last;
        idx = 0; cyc = 0; stalled = 0; done = 0; rst_hit = 0;
        prev = 16'h0; prev_last = 1'b0;
        got_q.delete();
        last_q.delete();
        while (!done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            arr_valid  = 1'b0;
            dout_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stalled) check("stall_hold", {14'd0, dout_valid, dout_last, dout},
                               {14'd0, 1'b1, prev_last, prev});
            check("valid_mid_packet", 32'(dout_valid), 32'd1);
            if (idx == rst_at) begin
                rst = 1'b1;
                rst_hit = 1;
                done = 1;
            end else begin
                if (idx == strobe_a || idx == strobe_b) arr_valid = 1'b1;
                if (dout_ready) begin
                    got_q.push_back(dout);
                    last_q.push_back(dout_last);
                    idx++;
                    stalled = 0;
                    if (dout_last) done = 1;
                end else begin
                    stalled = 1;
                    prev = dout;
                    prev_last = dout_last;
                end
            end
        end
        if (!done) check("packet_timeout", 32'd0, 32'd1);
        @(negedge clk);
        arr_valid = 1'b0;
        rst = 1'b0;
        if (!rst_hit && done) begin
            check("busy_after_last", 32'(busy), 32'd0);
            check("valid_after_last", 32'(dout_valid), 32'd0);
        end
    endtask

    task automatic compare_packet(input string tag);
        check({tag, "_len"}, 32'(got_q.size()), 32'(PKT_LEN));
        if (got_q.size() == PKT_LEN) begin
            for (int i = 0; i < PKT_LEN; i++) begin
                check({tag, "_word"}, {16'(i), got_q[i]}, {16'(i), exp_q[i]});
                check({tag, "_last"}, {16'(i), 15'd0, last_q[i]},
                      {16'(i), 15'd0, (i == PKT_LEN - 1)});
            end
        end
    endtask

    initial begin
        for (int r = 0; r < 38; r++) rows[r] = 38'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_dout", 32'(dout), 32'h0);
        check("reset_valid", 32'(dout_valid), 32'd0);
        check("reset_last", 32'(dout_last), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_drop", 32'(drop_cnt), 32'd0);

        // All-zero array, header 0x1234.
        array_header = 16'h1234;
        build_exp();
        start_packet();
        run_packet(0, -1, -1, -1);
        compare_packet("zero");
        if (got_q.size() == PKT_LEN) begin
            check("zero_header", 32'(got_q[0]), 32'h1234);
            check("zero_row5_a", 32'(got_q[16]), 32'h1400);
            check("zero_row37_a", 32'(got_q[112]), 32'h9400);
            check("zero_trailer", 32'(got_q[115]), 32'hF000);
        end

        // Single populated row.
        rows[5] = 38'h3F_0000_0001;
        array_header = 16'hA5C3;
        build_exp();
        start_packet();
        run_packet(0, -1, -1, -1);
        compare_packet("row5");
        if (got_q.size() == PKT_LEN) begin
            check("row5_w16", 32'(got_q[16]), 32'h143F);
            check("row5_w17", 32'(got_q[17]), 32'h0000);
            check("row5_w18", 32'(got_q[18]), 32'h0001);
            check("row5_trailer", 32'(got_q[115]), 32'hF007);
        end

        // Random array, full rate then random backpressure.
        for (int r = 0; r < 38; r++) rows[r] = {6'($urandom_range(0, 63)), 32'($urandom)};
        array_header = 16'($urandom);
        build_exp();
        start_packet();
        run_packet(0, -1, -1, -1);
        compare_packet("rand_full");
        ref_q = got_q;
        start_packet();
        run_packet(1, -1, -1, -1);
        compare_packet("rand_stall");
        check("rand_same_len", 32'(got_q.size()), 32'(ref_q.size()));
        if (got_q.size() == ref_q.size())
            for (int i = 0; i < got_q.size(); i++)
                check("rand_same_word", {16'(i), got_q[i]}, {16'(i), ref_q[i]});

        // Strobes at word 40 and during the final handshake are both dropped.
        start_packet();
        run_packet(0, 40, PKT_LEN - 1, -1);
        compare_packet("drop");
        check("drop_cnt_two", 32'(drop_cnt), 32'd2);

        // Reset mid-packet, then a full packet afterwards.
        start_packet();
        run_packet(0, -1, -1, 60);
        check("rst_hit", 32'(rst_hit), 32'd1);
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        check("rst_last", 32'(dout_last), 32'd0);
        check("rst_dout", 32'(dout), 32'h0);
        rows[0] = 38'h2A_FFFF_0F0F;
        build_exp();
        start_packet();
        run_packet(0, -1, -1, -1);
        compare_packet("post_rst");

        // Reset wins over a simultaneous strobe.
        @(negedge clk);
        rst = 1'b1;
        arr_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        arr_valid = 1'b0;
        check("rst_vs_strobe_busy", 32'(busy), 32'd0);
        check("rst_vs_strobe_valid", 32'(dout_valid), 32'd0);
        @(negedge clk);
        check("rst_vs_strobe_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
